// File: rtl/obj_linelatch_gen.sv
// Object line latch: queues CHARRAM tile-line words (pending + active) and serialises them into {palette,pixel} pairs; OBJ_LINELATCH_TRANSP_EN suppresses pen-0 writes.
// Latency: a load on CE tick N gives the first pair registered at N+3, then one pair per 2 unstalled ticks.
// Backpressure: o_READY is low while the pending slot is full (loads then drop and set sticky o_OVF); i_WAIT_n=0 freezes the sequencer.
module obj_linelatch_gen #(
  parameter int BPP         = 4,
  parameter int PX_PER_WORD = 8,
  parameter int PAL_W       = 4,
  parameter int CNT_W       = $clog2(PX_PER_WORD)
) (
  input  logic                       i_EMU_MCLK,
  input  logic                       i_EMU_RST,
  input  logic                       i_EMU_CLK6MPCEN_n,
  input  logic [BPP*PX_PER_WORD-1:0] i_GFXDATA,
  input  logic [PAL_W-1:0]           i_OC,
  input  logic                       i_COLORLATCH_n,
  input  logic                       i_TILELINELATCH_n,
  input  logic                       i_HFLIP,
  input  logic                       i_WAIT_n,
  input  logic                       i_XPOS_D0,
  output logic [PAL_W+BPP-1:0]       o_DA,
  output logic [PAL_W+BPP-1:0]       o_DB,
  output logic                       o_WE_A,
  output logic                       o_WE_B,
  output logic                       o_PAIR_VALID,
  output logic                       o_READY,
  output logic                       o_BUSY,
  output logic                       o_OVF
);

  localparam int WORD_W = BPP*PX_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PX_PER_WORD-1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [PAL_W-1:0]     pal_q;
  logic                 pend_vld_q;
  logic [WORD_W-1:0]    pend_dat_q;
  logic [PAL_W-1:0]     pend_pal_q;
  logic                 pend_flip_q;
  logic [WORD_W-1:0]    act_dat_q;
  logic [PAL_W-1:0]     act_pal_q;
  logic                 act_flip_q;
  logic [CNT_W-1:0]     idx_q;
  logic [BPP-1:0]       p0_q;
  logic [PAL_W+BPP-1:0] da_q, db_q;
  logic                 pair_vld_q;
  logic                 ovf_q;

  logic ce, load_req, load_acc, run_adv, last_px, xfer, busy;
  logic [CNT_W-1:0] slot;
  logic [BPP-1:0]   cur_pix, pix_a, pix_b;

  always_comb begin
    ce       = ~i_EMU_CLK6MPCEN_n;
    load_req = ce & ~i_TILELINELATCH_n;
    load_acc = load_req & ~pend_vld_q;
    run_adv  = ce & (state_q == RUN) & i_WAIT_n;
    last_px  = (idx_q == LAST_IDX);
  end

  // Pixel 0 sits in the MSBs, so the unflipped walk reads slots from the top down.
  always_comb begin
    slot    = act_flip_q ? idx_q : LAST_IDX - idx_q;
    cur_pix = '0;
    for (int k = 0; k < PX_PER_WORD; k++) begin
      if (slot == CNT_W'(k)) cur_pix = act_dat_q[k*BPP +: BPP];
    end
    pix_a = i_XPOS_D0 ? cur_pix : p0_q;
    pix_b = i_XPOS_D0 ? p0_q : cur_pix;
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST)  state_q <= IDLE;
    else if (ce)    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_vld_q) state_d = RUN;
      RUN:     if (run_adv && last_px && !pend_vld_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last pixel of a word and the hand-over of the next one share a tick, so no bubble.
  always_comb begin
    xfer = 1'b0;
    busy = 1'b0;
    case (state_q)
      IDLE: xfer = ce & pend_vld_q;
      RUN: begin
        busy = 1'b1;
        xfer = run_adv & last_px & pend_vld_q;
      end
      default: ;
    endcase
  end

`ifdef OBJ_LINELATCH_TRANSP_EN
  logic we_a_q, we_b_q;
`endif

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      pal_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_dat_q  <= '0;
      pend_pal_q  <= '0;
      pend_flip_q <= 1'b0;
      act_dat_q   <= '0;
      act_pal_q   <= '0;
      act_flip_q  <= 1'b0;
      idx_q       <= '0;
      p0_q        <= '0;
      da_q        <= '0;
      db_q        <= '0;
      pair_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef OBJ_LINELATCH_TRANSP_EN
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
`endif
    end else if (ce) begin
      if (!i_COLORLATCH_n) pal_q <= i_OC;
      if (load_req && pend_vld_q) ovf_q <= 1'b1;

      if (load_acc) begin
        pend_vld_q  <= 1'b1;
        pend_dat_q  <= i_GFXDATA;
        pend_pal_q  <= !i_COLORLATCH_n ? i_OC : pal_q;
        pend_flip_q <= i_HFLIP;
      end else if (xfer) begin
        pend_vld_q  <= 1'b0;
      end

      if (xfer) begin
        act_dat_q  <= pend_dat_q;
        act_pal_q  <= pend_pal_q;
        act_flip_q <= pend_flip_q;
        idx_q      <= '0;
      end else if (run_adv) begin
        idx_q      <= idx_q + CNT_W'(1);
      end

      pair_vld_q <= 1'b0;
`ifdef OBJ_LINELATCH_TRANSP_EN
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
`endif
      if (run_adv) begin
        if (!idx_q[0]) begin
          p0_q <= cur_pix;
        end else begin
          pair_vld_q <= 1'b1;
`ifdef OBJ_LINELATCH_TRANSP_EN
          da_q   <= (pix_a == '0) ? '0 : {act_pal_q, pix_a};
          db_q   <= (pix_b == '0) ? '0 : {act_pal_q, pix_b};
          we_a_q <= |pix_a;
          we_b_q <= |pix_b;
`else
          da_q   <= {act_pal_q, pix_a};
          db_q   <= {act_pal_q, pix_b};
`endif
        end
      end
    end
  end

`ifdef OBJ_LINELATCH_TRANSP_EN
  assign o_WE_A = we_a_q;
  assign o_WE_B = we_b_q;
`else
  assign o_WE_A = pair_vld_q;
  assign o_WE_B = pair_vld_q;
`endif

  assign o_DA         = da_q;
  assign o_DB         = db_q;
  assign o_PAIR_VALID = pair_vld_q;
  assign o_READY      = ~pend_vld_q;
  assign o_BUSY       = busy;
  assign o_OVF        = ovf_q;

endmodule

// File: tb/tb_obj_linelatch_gen.sv
// Bench for obj_linelatch_gen: directed vector table, hand-written corner sequences and a randomized run against a word-queue model.
module tb_obj_linelatch_gen;

  logic        mclk = 1'b0;
  logic        rst, ce_n, col_n, ld_n, hflip, wait_n, xpos;
  logic [31:0] gfx;
  logic [3:0]  oc;
  logic [7:0]  da, db;
  logic        we_a, we_b, pv, ready, busy, ovf;

  int errors = 0;
  int checks = 0;

  always #5 mclk = ~mclk;

  obj_linelatch_gen dut (
    .i_EMU_MCLK        (mclk),
    .i_EMU_RST         (rst),
    .i_EMU_CLK6MPCEN_n (ce_n),
    .i_GFXDATA         (gfx),
    .i_OC              (oc),
    .i_COLORLATCH_n    (col_n),
    .i_TILELINELATCH_n (ld_n),
    .i_HFLIP           (hflip),
    .i_WAIT_n          (wait_n),
    .i_XPOS_D0         (xpos),
    .o_DA              (da),
    .o_DB              (db),
    .o_WE_A            (we_a),
    .o_WE_B            (we_b),
    .o_PAIR_VALID      (pv),
    .o_READY           (ready),
    .o_BUSY            (busy),
    .o_OVF             (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle_in();
    rst = 1'b0; ce_n = 1'b0; col_n = 1'b1; ld_n = 1'b1;
    hflip = 1'b0; wait_n = 1'b1; xpos = 1'b0; gfx = '0; oc = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] w, input logic [3:0] p, input logic f);
    ld_n = 1'b0; col_n = 1'b0; gfx = w; oc = p; hflip = f;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, ld_n;
    logic [31:0] gfx;
    logic [3:0]  oc;
    logic        flip, wait_n, xpos;
    logic        e_pv;
    logic [7:0]  e_da, e_db;
    logic        e_busy, e_ready;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] W1 = 32'h12345678;

  function automatic vec_t rrst();
    vec_t v = '{1'b1, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    return v;
  endfunction

  function automatic vec_t rld(input logic f, input logic x);
    vec_t v = '{1'b0, 1'b0, W1, 4'hA, f, 1'b1, x, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic vec_t rw(input logic w, input logic x, input logic p,
                              input logic [7:0] a, input logic [7:0] b, input logic bz);
    vec_t v = '{1'b0, 1'b1, 32'h0, 4'h0, 1'b0, w, x, p, a, b, bz, 1'b1};
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] w; logic [3:0] pal; logic fl; } wrd_t;

  wrd_t       m_pend[$];
  wrd_t       m_act;
  bit         m_has_act;
  int         m_pos;
  logic [3:0] m_first, m_pal;
  logic       e_pv, e_wea, e_web, e_ovf;
  logic [7:0] e_da, e_db;

  function automatic logic [3:0] pix_of(input wrd_t x, input int pos);
    int k = x.fl ? 7 - pos : pos;
    logic [31:0] t = x.w >> ((7 - k) * 4);
    return t[3:0];
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_has_act = 0; m_pos = 0; m_first = '0; m_pal = '0;
    e_pv = 0; e_wea = 0; e_web = 0; e_ovf = 0; e_da = '0; e_db = '0;
  endtask

  task automatic model_step();
    bit had_pend;
    logic [3:0] p, a, b;
    if (rst) begin
      model_reset();
    end else if (!ce_n) begin
      had_pend = (m_pend.size() != 0);
      e_pv = 0; e_wea = 0; e_web = 0;
      if (!m_has_act) begin
        if (had_pend) begin
          m_act = m_pend.pop_front(); m_has_act = 1; m_pos = 0;
        end
      end else if (wait_n) begin
        p = pix_of(m_act, m_pos);
        if (m_pos % 2 == 0) begin
          m_first = p;
        end else begin
          e_pv = 1;
          a = xpos ? p : m_first;
          b = xpos ? m_first : p;
`ifdef OBJ_LINELATCH_TRANSP_EN
          e_da = (a == 0) ? 8'h00 : {m_act.pal, a};
          e_db = (b == 0) ? 8'h00 : {m_act.pal, b};
          e_wea = (a != 0);
          e_web = (b != 0);
`else
          e_da = {m_act.pal, a};
          e_db = {m_act.pal, b};
          e_wea = 1; e_web = 1;
`endif
        end
        m_pos++;
        if (m_pos == 8) begin
          if (had_pend) begin
            m_act = m_pend.pop_front(); m_pos = 0;
          end else begin
            m_has_act = 0;
          end
        end
      end
      if (!ld_n) begin
        if (had_pend) e_ovf = 1;
        else m_pend.push_back('{gfx, col_n ? m_pal : oc, hflip});
      end
      if (!col_n) m_pal = oc;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got[$];
    logic [15:0] exp_b2b[8];
    logic [7:0]  t_da[4], t_db[4];
    logic        t_wa[4], t_wb[4];
    int          n;

    idle_in();

    // Scenario 1: plain word, no flip, XPOS=0
    tbl.push_back(rrst());
    tbl.push_back(rld(1'b0, 1'b0));
    tbl.push_back(rw(1, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA1, 8'hA2, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA1, 8'hA2, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA7, 8'hA8, 0));
    tbl.push_back(rw(1, 0, 0, 8'hA7, 8'hA8, 0));
    // Scenario 2: flipped, XPOS=1
    tbl.push_back(rrst());
    tbl.push_back(rld(1'b1, 1'b1));
    tbl.push_back(rw(1, 1, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 1, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 1, 1, 8'hA7, 8'hA8, 1));
    tbl.push_back(rw(1, 1, 0, 8'hA7, 8'hA8, 1));
    tbl.push_back(rw(1, 1, 1, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 1, 0, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 1, 1, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 1, 0, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 1, 1, 8'hA1, 8'hA2, 0));
    tbl.push_back(rw(1, 1, 0, 8'hA1, 8'hA2, 0));
    // Scenario 3: 5-tick stall after the first pair
    tbl.push_back(rrst());
    tbl.push_back(rld(1'b0, 1'b0));
    tbl.push_back(rw(1, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 0, 0, 8'h00, 8'h00, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA1, 8'hA2, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(rw(0, 0, 0, 8'hA1, 8'hA2, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA1, 8'hA2, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA3, 8'hA4, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 0, 0, 8'hA5, 8'hA6, 1));
    tbl.push_back(rw(1, 0, 1, 8'hA7, 8'hA8, 0));
    tbl.push_back(rw(1, 0, 0, 8'hA7, 8'hA8, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ld_n = tbl[i].ld_n; col_n = tbl[i].ld_n;
      gfx = tbl[i].gfx; oc = tbl[i].oc; hflip = tbl[i].flip;
      wait_n = tbl[i].wait_n; xpos = tbl[i].xpos; ce_n = 1'b0;
      tick();
      chk($sformatf("vec%0d pair_valid", i), pv, tbl[i].e_pv);
      chk($sformatf("vec%0d da", i), da, tbl[i].e_da);
      chk($sformatf("vec%0d db", i), db, tbl[i].e_db);
      chk($sformatf("vec%0d we_a", i), we_a, tbl[i].e_pv);
      chk($sformatf("vec%0d we_b", i), we_b, tbl[i].e_pv);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d ready", i), ready, tbl[i].e_ready);
      chk($sformatf("vec%0d ovf", i), ovf, 1'b0);
    end

    // Back-to-back words, third load overflows and is dropped
    do_reset();
    exp_b2b = '{16'hA1A2, 16'hA3A4, 16'hA5A6, 16'hA7A8,
                16'hB9BA, 16'hBBBC, 16'hBDBE, 16'hBFB1};
    for (int t = 0; t <= 20; t++) begin
      idle_in();
      if (t == 0) load(W1, 4'hA, 1'b0);
      if (t == 2) load(32'h9ABCDEF1, 4'hB, 1'b0);
      if (t == 5) load(32'h11111111, 4'h3, 1'b0);
      tick();
      if (pv) got.push_back({da, db});
      if (t >= 2 && t <= 8) chk($sformatf("b2b ready_low t%0d", t), ready, 1'b0);
      if (t == 9)  chk("b2b ready_after_xfer", ready, 1'b1);
      if (t == 4)  chk("b2b ovf_before", ovf, 1'b0);
      if (t == 5)  chk("b2b ovf_set", ovf, 1'b1);
      if (t == 11) chk("b2b no_gap_pv", pv, 1'b1);
      if (t == 20) chk("b2b ovf_sticky", ovf, 1'b1);
    end
    chk("b2b pair_count", got.size(), 8);
    n = (got.size() < 8) ? got.size() : 8;
    for (int i = 0; i < n; i++) chk($sformatf("b2b pair%0d", i), got[i], exp_b2b[i]);

    // Transparent pens
    do_reset();
`ifdef OBJ_LINELATCH_TRANSP_EN
    t_da = '{8'hA1, 8'h00, 8'h00, 8'h00}; t_db = '{8'h00, 8'hA2, 8'h00, 8'h00};
    t_wa = '{1'b1, 1'b0, 1'b0, 1'b0};     t_wb = '{1'b0, 1'b1, 1'b0, 1'b0};
`else
    t_da = '{8'hA1, 8'hA0, 8'hA0, 8'hA0}; t_db = '{8'hA0, 8'hA2, 8'hA0, 8'hA0};
    t_wa = '{1'b1, 1'b1, 1'b1, 1'b1};     t_wb = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t <= 10; t++) begin
      idle_in();
      if (t == 0) load(32'h10020000, 4'hA, 1'b0);
      tick();
      if (t == 3 || t == 5 || t == 7 || t == 9) begin
        chk($sformatf("transp pv t%0d", t), pv, 1'b1);
        chk($sformatf("transp da t%0d", t), da, t_da[(t-3)/2]);
        chk($sformatf("transp db t%0d", t), db, t_db[(t-3)/2]);
        chk($sformatf("transp we_a t%0d", t), we_a, t_wa[(t-3)/2]);
        chk($sformatf("transp we_b t%0d", t), we_b, t_wb[(t-3)/2]);
      end
    end

    // Reset after the second pair of a word
    do_reset();
    n = 0;
    for (int t = 0; t <= 16; t++) begin
      idle_in();
      if (t == 0) load(W1, 4'hA, 1'b0);
      if (t == 6) rst = 1'b1;
      tick();
      if (t == 5) chk("rst_mid pair2", {da, db}, 16'hA3A4);
      if (t == 6) begin
        chk("rst_mid outs", {pv, da, db, we_a, we_b, busy, ovf}, '0);
        chk("rst_mid ready", ready, 1'b1);
      end
      if (t > 6 && pv) n++;
    end
    chk("rst_mid no_more_pairs", n, 0);
    for (int t = 0; t <= 3; t++) begin
      idle_in();
      if (t == 0) load(W1, 4'hA, 1'b0);
      tick();
      if (t == 3) chk("rst_mid fresh_pair", {pv, da, db}, {1'b1, 16'hA1A2});
    end

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      ce_n   = ($urandom_range(0, 4) == 0);
      ld_n   = ($urandom_range(0, 5) != 0);
      col_n  = ($urandom_range(0, 3) != 0);
      hflip  = $urandom_range(0, 1) != 0;
      wait_n = ($urandom_range(0, 6) != 0);
      xpos   = $urandom_range(0, 1) != 0;
      gfx    = $urandom & $urandom;
      oc     = 4'($urandom);
      model_step();
      tick();
      chk($sformatf("rand c%0d {pv,da,db,wea,web,busy,ready,ovf}", c),
          {pv, da, db, we_a, we_b, busy, ready, ovf},
          {e_pv, e_da, e_db, e_wea, e_web, m_has_act, (m_pend.size() == 0), e_ovf});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
